// File: rtl/ysyx_22050710_if_stage.sv
// IF stage: pairs inst-SRAM read data with its PC; data is valid one cycle after o_pc_load.
// When ID stalls, the pair moves to a skid buffer and fetching stops; a taken branch kills IF and refetches.
module ysyx_22050710_if_stage #(
  parameter int PC_WD   = 64,
  parameter int INST_WD = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [PC_WD-1:0]   i_pc,
  output logic               o_pc_load,
  input  logic               i_br_taken,
  input  logic [INST_WD-1:0] i_inst_sram_rdata,
  input  logic               i_id_allowin,
  output logic               o_if_valid,
  output logic [PC_WD-1:0]   o_if_pc,
  output logic [INST_WD-1:0] o_if_inst
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SRAM  = 2'd1,
    BUF   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PC_WD-1:0]   buf_pc;
  logic [INST_WD-1:0] buf_inst;
  logic               allowin;
  logic               buf_we;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // SRAM data is only valid for one cycle, so it must be captured on the stall edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_pc   <= '0;
      buf_inst <= '0;
    end else if (buf_we) begin
      buf_pc   <= i_pc;
      buf_inst <= i_inst_sram_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    allowin   = (state == EMPTY) | i_id_allowin | i_br_taken;
    buf_we    = 1'b0;
    o_if_pc   = '0;
    o_if_inst = '0;
    case (state)
      EMPTY: begin
        state_nxt = SRAM;
      end
      SRAM: begin
        o_if_pc   = i_pc;
        o_if_inst = i_inst_sram_rdata;
        if (!allowin) begin
          state_nxt = BUF;
          buf_we    = 1'b1;
        end
      end
      BUF: begin
        o_if_pc   = buf_pc;
        o_if_inst = buf_inst;
        if (allowin) begin
          state_nxt = SRAM;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  assign o_pc_load  = allowin & i_rst_n;
  assign o_if_valid = (state != EMPTY) & ~i_br_taken;

endmodule

// File: tb/tb_ysyx_22050710_if_stage.sv
// Bench for the IF stage: PC register and inst SRAM are modelled here; a held-instruction model checks every cycle.
module tb_ysyx_22050710_if_stage;

  localparam logic [63:0] BOOT = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pc;
  logic        pc_load;
  logic        br_taken;
  logic [31:0] rdata;
  logic        id_allowin;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_inst;

  ysyx_22050710_if_stage #(.PC_WD(64), .INST_WD(32)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_pc              (pc),
    .o_pc_load         (pc_load),
    .i_br_taken        (br_taken),
    .i_inst_sram_rdata (rdata),
    .i_id_allowin      (id_allowin),
    .o_if_valid        (if_valid),
    .o_if_pc           (if_pc),
    .o_if_inst         (if_inst)
  );

  always #5 clk = ~clk;

  int          checks  = 0;
  int          errors  = 0;
  int          accepts = 0;
  logic        chk_en  = 1'b0;
  logic        have;
  logic [63:0] m_pc;
  logic [63:0] exp_accept;
  logic [63:0] br_tgt;
  logic        exp_valid;
  logic        exp_load;
  logic        ld;

  function automatic logic [31:0] mem(input logic [63:0] a);
    if (a == 64'h8000_0008) return 32'hdead_beef;
    return {a[15:0] ^ 16'h1234, a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model view: IF shows the most recently fetched instruction until a fetch replaces it.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 64'(if_valid), 64'(exp_valid));
      chk("pc_load", 64'(pc_load), 64'(exp_load));
      if (exp_valid) begin
        chk("if_pc", if_pc, m_pc);
        chk("if_inst", 64'(if_inst), 64'(mem(m_pc)));
      end else if (!have) begin
        chk("empty_pc", if_pc, 64'd0);
        chk("empty_inst", 64'(if_inst), 64'd0);
      end
      if (if_valid && id_allowin) begin
        chk("accept_pc", if_pc, exp_accept);
        exp_accept = exp_accept + 64'd4;
        accepts++;
      end
    end
  end

  task automatic drive(input logic allow, input logic br, input logic [63:0] tgt);
    id_allowin = allow;
    br_taken   = br;
    br_tgt     = tgt;
    exp_valid  = have & ~br;
    exp_load   = ~have | allow | br;
    @(negedge clk);
    ld = pc_load;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (ld) begin
      pc    = br_taken ? br_tgt : pc + 64'd4;
      rdata = mem(pc);
    end else begin
      rdata = $urandom;
    end
    if (exp_load) begin
      have = 1'b1;
      m_pc = br_taken ? br_tgt : m_pc + 64'd4;
    end
    if (br_taken) exp_accept = br_tgt;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pc         = BOOT - 64'd4;
    rdata      = $urandom;
    have       = 1'b0;
    m_pc       = BOOT - 64'd4;
    exp_accept = BOOT;
    rst_n      = 1'b1;
    chk_en     = 1'b1;
  endtask

  task automatic boot_seq();
    drive(1'b1, 1'b0, 64'd0);
    chk("c0_load", 64'(pc_load), 64'd1);
    chk("c0_valid", 64'(if_valid), 64'd0);
    advance();
    drive(1'b1, 1'b0, 64'd0);
    chk("c1_valid", 64'(if_valid), 64'd1);
    chk("c1_pc", if_pc, 64'h8000_0000);
    chk("c1_inst", 64'(if_inst), 64'h1234_8000);
    advance();
    drive(1'b1, 1'b0, 64'd0);
    chk("c2_pc", if_pc, 64'h8000_0004);
    chk("c2_inst", 64'(if_inst), 64'h1230_8000);
    advance();
  endtask

  initial begin
    rst_n      = 1'b0;
    id_allowin = 1'b0;
    br_taken   = 1'b0;
    br_tgt     = 64'd0;
    pc         = 64'd0;
    rdata      = 32'd0;
    have       = 1'b0;
    m_pc       = BOOT - 64'd4;
    exp_accept = BOOT;
    exp_valid  = 1'b0;
    exp_load   = 1'b0;
    ld         = 1'b0;
    #2;
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_load", 64'(pc_load), 64'd0);
    chk("rst_pc", if_pc, 64'd0);
    do_reset();

    boot_seq();

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 64'd0);
      chk("stall_pc", if_pc, 64'h8000_0008);
      chk("stall_inst", 64'(if_inst), 64'hdead_beef);
      chk("stall_load", 64'(pc_load), 64'd0);
      advance();
    end
    drive(1'b1, 1'b0, 64'd0);
    chk("release_pc", if_pc, 64'h8000_0008);
    chk("release_load", 64'(pc_load), 64'd1);
    advance();
    drive(1'b1, 1'b0, 64'd0);
    chk("after_stall_pc", if_pc, 64'h8000_000c);
    advance();

    drive(1'b1, 1'b1, 64'h8000_0100);
    chk("br_valid", 64'(if_valid), 64'd0);
    chk("br_load", 64'(pc_load), 64'd1);
    advance();
    drive(1'b1, 1'b0, 64'd0);
    chk("br_tgt_pc", if_pc, 64'h8000_0100);
    advance();

    drive(1'b0, 1'b0, 64'd0);
    advance();
    drive(1'b0, 1'b0, 64'd0);
    chk("buf_hold_pc", if_pc, 64'h8000_0104);
    advance();
    drive(1'b0, 1'b1, 64'h8000_0200);
    chk("buf_br_valid", 64'(if_valid), 64'd0);
    chk("buf_br_load", 64'(pc_load), 64'd1);
    advance();
    drive(1'b0, 1'b0, 64'd0);
    chk("buf_br_tgt_valid", 64'(if_valid), 64'd1);
    chk("buf_br_tgt_pc", if_pc, 64'h8000_0200);
    advance();

    drive(1'b0, 1'b0, 64'd0);
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("arst_valid", 64'(if_valid), 64'd0);
    chk("arst_load", 64'(pc_load), 64'd0);
    chk("arst_pc", if_pc, 64'd0);
    do_reset();
    boot_seq();

    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b0, 64'd0);
      advance();
    end

    checks++;
    if (accepts < 300) begin
      errors++;
      $display("FAIL accept_count: got %0d expected at least 300", accepts);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050710_if_stage.md
Name: ysyx_22050710_if_stage

Overview:
- Instruction-fetch stage directly downstream of the program-counter register.
- Drives the PC register's load enable and captures the synchronous inst-SRAM read data.
- Pairs each returned instruction with its PC and presents the pair to the ID stage over a valid/allowin handshake.
- Holds the instruction in a skid buffer when ID stalls, and discards wrong-path fetches when ID redirects on a taken branch.

Parameters:
- PC_WD, 64, width of PC values.
- INST_WD, 32, instruction and inst-SRAM read-data width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_pc  in  PC_WD  current PC register output; equals the address whose data appears on i_inst_sram_rdata this cycle.
- o_pc_load  out  1  write enable to the PC register; also the inst-SRAM read enable.
- i_br_taken  in  1  taken-branch redirect from ID; kills the instruction currently held in IF.
- i_inst_sram_rdata  in  INST_WD  SRAM read data, valid the cycle after a load.
- i_id_allowin  in  1  ID can accept an instruction this cycle.
- o_if_valid  out  1  IF holds a valid instruction for ID.
- o_if_pc  out  PC_WD  PC of the presented instruction.
- o_if_inst  out  INST_WD  presented instruction.

Behaviour:
- States:
  - EMPTY: nothing held.
  - SRAM: instruction is on i_inst_sram_rdata, PC is i_pc.
  - BUF: instruction and PC are held in internal registers.
- Reset (async, i_rst_n=0): state=EMPTY, buffer registers=0, o_if_valid=0, o_pc_load=0, o_if_pc=0, o_if_inst=0. All take effect immediately, including mid-fetch; any in-flight SRAM data is ignored.
- allowin = (state==EMPTY) | i_id_allowin | i_br_taken.
- o_pc_load = allowin & reset deasserted. It is combinational and asserted in the first cycle after reset release.
- o_if_valid = (state!=EMPTY) & ~i_br_taken. It is combinational, so a killed instruction is never presented.
- Output muxing:
  - In SRAM state: o_if_pc=i_pc, o_if_inst=i_inst_sram_rdata.
  - In BUF state: o_if_pc and o_if_inst come from the buffer registers.
  - In EMPTY state: both outputs are 0.
- Transitions:
  - EMPTY -> SRAM (a load is always issued).
  - SRAM with i_id_allowin=1 or i_br_taken=1 -> SRAM. The new fetch's data arrives next cycle.
  - SRAM with i_id_allowin=0 and i_br_taken=0 -> BUF. Latch i_pc and i_inst_sram_rdata into the buffer; o_pc_load=0.
  - BUF with i_id_allowin=0 and i_br_taken=0 -> BUF. Buffer contents are held unchanged.
  - BUF with i_id_allowin=1 or i_br_taken=1 -> SRAM. The buffer contents are consumed or discarded.
- Latency and throughput:
  - One cycle from o_pc_load to the instruction being valid at the output.
  - Sustained throughput is 1 instruction/cycle while i_id_allowin=1.
- Branch:
  - i_br_taken in any state discards the IF content and forces o_pc_load=1, which fetches the target.
  - The next cycle presents the target instruction.
  - i_br_taken together with i_id_allowin=0 still reloads; ID must tolerate this.
- Stall: no instruction is dropped or duplicated across any stall length. The buffer is written only on the SRAM->BUF transition.
- Widths: no arithmetic in this block. PC is passed through unmodified at PC_WD.

Test Plan:
- Reset release with i_id_allowin=1 and a PC model at boot 0x80000000:
  - Cycle 0: o_pc_load=1, o_if_valid=0.
  - Cycle 1: o_if_valid=1, o_if_pc=0x80000000, inst=mem[0].
  - Then one instruction per cycle at 0x80000004, 0x80000008, and so on.
- Stall: hold i_id_allowin=0 for 3 cycles while 0x80000008 / 0xdeadbeef is presented.
  - o_if_pc and o_if_inst stay constant and o_pc_load=0 for all 3 cycles, even though the SRAM data bus is driven with garbage.
  - On release, 0x80000008 is accepted once and 0x8000000c follows.
- Branch: i_br_taken=1 with target 0x80000100 while IF holds 0x80000010.
  - Same cycle: o_if_valid=0, o_pc_load=1.
  - Next cycle: o_if_pc=0x80000100; 0x80000010 is never accepted.
- Branch while in BUF state: stall for 2 cycles, then assert i_br_taken with i_id_allowin=0.
  - The buffer is discarded and the state goes to SRAM.
  - The target instruction appears next cycle.
- Async reset mid-stream: pull i_rst_n low between clock edges while in BUF state.
  - o_if_valid=0 and o_pc_load=0 immediately.
  - After release, the fetch sequence restarts as in the first scenario.
- Random i_id_allowin at 50% over 1000 cycles, checked against a scoreboard: the accepted PC sequence is strictly sequential (+4) with no gaps or duplicates.
